// File: rtl/elevator_pkg.sv
// Shared types and constants for the four-floor elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_e;

    localparam logic [1:0] FLOOR_1 = 2'd0;
    localparam logic [1:0] FLOOR_2 = 2'd1;
    localparam logic [1:0] FLOOR_3 = 2'd2;
    localparam logic [1:0] FLOOR_4 = 2'd3;

    // Active-low segments {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_1 = 7'b1111001;
    localparam logic [6:0] HEX_2 = 7'b0100100;
    localparam logic [6:0] HEX_3 = 7'b0110000;
    localparam logic [6:0] HEX_4 = 7'b0011001;

    localparam int DEF_MOVE_LIMIT = 50;
    localparam int DEF_DOOR_LIMIT = 100;

    function automatic logic [3:0] upper_mask(input logic [1:0] f);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    function automatic logic [3:0] lower_mask(input logic [1:0] f);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (i < int'(f));
        return m;
    endfunction

endpackage

// File: rtl/elevator_fsm_floor_to_hex.sv
// 2-bit floor index to active-low seven-segment digit "1".."4".
module floor_to_hex
    import elevator_pkg::*;
(
    input  logic [1:0] floor_i,
    output logic [6:0] hex_o
);

    always_comb begin
        hex_o = HEX_1;
        case (floor_i)
            FLOOR_1: hex_o = HEX_1;
            FLOOR_2: hex_o = HEX_2;
            FLOOR_3: hex_o = HEX_3;
            FLOOR_4: hex_o = HEX_4;
            default: hex_o = HEX_1;
        endcase
    end

endmodule

// File: rtl/elevator_fsm.sv
// Four-floor SCAN elevator: latches hall/cabin calls, moves one floor per
// MOVE_LIMIT cycles, dwells DOOR_LIMIT cycles, shows floor on HEX0.
module elevator_fsm
    import elevator_pkg::*;
#(
    parameter int MOVE_LIMIT = DEF_MOVE_LIMIT,
    parameter int DOOR_LIMIT = DEF_DOOR_LIMIT
) (
    input  logic        CLOCK_50,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [6:0]  HEX0,
    output logic [8:0]  LEDG,
    output logic [3:0]  LEDR
);

    localparam int MAXL = (MOVE_LIMIT > DOOR_LIMIT) ? MOVE_LIMIT : DOOR_LIMIT;
    localparam int TW   = $clog2(MAXL + 1);
    localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_LIMIT - 1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_LIMIT - 1);

    logic rst_n;
    logic unused_sw;
    assign rst_n     = SW[17];
    assign unused_sw = ^SW[16:4];

    state_e        state_q, state_d;
    logic [1:0]    floor_q, floor_d;
    logic          dir_up_q, dir_up_d;
    logic [3:0]    req_q, req_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          above, below;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            floor_q  <= FLOOR_1;
            dir_up_q <= 1'b1;
            req_q    <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_up_q <= dir_up_d;
            req_q    <= req_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        timer_d  = '0;
        above    = |(req_q & upper_mask(floor_q));
        below    = |(req_q & lower_mask(floor_q));
        case (state_q)
            ST_IDLE: begin
                if (req_q[floor_q])           state_d = ST_DOOR_OPEN;
                else if (dir_up_q && above)   state_d = ST_MOVE_UP;
                else if (!dir_up_q && below)  state_d = ST_MOVE_DOWN;
                else if (above) begin
                    dir_up_d = 1'b1;
                    state_d  = ST_MOVE_UP;
                end else if (below) begin
                    dir_up_d = 1'b0;
                    state_d  = ST_MOVE_DOWN;
                end
            end
            ST_MOVE_UP: begin
                if (floor_q == FLOOR_4) begin
                    state_d = ST_IDLE;
                end else if (timer_q == MOVE_LAST) begin
                    floor_d = floor_q + 2'd1;
                    if (req_q[floor_d])                          state_d = ST_DOOR_OPEN;
                    else if (!(|(req_q & upper_mask(floor_d))))  state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_MOVE_DOWN: begin
                if (floor_q == FLOOR_1) begin
                    state_d = ST_IDLE;
                end else if (timer_q == MOVE_LAST) begin
                    floor_d = floor_q - 2'd1;
                    if (req_q[floor_d])                          state_d = ST_DOOR_OPEN;
                    else if (!(|(req_q & lower_mask(floor_d))))  state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DOOR_OPEN: begin
                if (timer_q == DOOR_LAST) state_d = ST_IDLE;
                else                      timer_d = timer_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Calls for the floor being served are dropped on arrival and for the whole dwell
        req_d = req_q | SW[3:0] | ~KEY;
        if (state_q == ST_DOOR_OPEN || state_d == ST_DOOR_OPEN) req_d[floor_d] = 1'b0;
    end

    floor_to_hex u_hex (
        .floor_i (floor_q),
        .hex_o   (HEX0)
    );

    assign LEDR = req_q;
    assign LEDG = {|req_q, 4'b0001 << floor_q,
                   state_q == ST_IDLE, state_q == ST_DOOR_OPEN,
                   state_q == ST_MOVE_DOWN, state_q == ST_MOVE_UP};

endmodule

// File: tb/tb_elevator_fsm.sv
// Directed bench for elevator_fsm: hand-timed trips, reversal, door ignore, async reset.
module tb_elevator_fsm;

    logic        clk = 1'b0;
    logic [17:0] SW;
    logic [3:0]  KEY;
    logic [6:0]  HEX0;
    logic [8:0]  LEDG;
    logic [3:0]  LEDR;

    int n_pass = 0;
    int n_tot  = 0;

    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H3 = 7'b0110000;
    localparam logic [6:0] H4 = 7'b0011001;

    always #10 clk = ~clk;

    elevator_fsm dut (
        .CLOCK_50 (clk),
        .SW       (SW),
        .KEY      (KEY),
        .HEX0     (HEX0),
        .LEDG     (LEDG),
        .LEDR     (LEDR)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_sw(input logic [3:0] b);
        SW[3:0] = b;
        ticks(1);
        SW[3:0] = 4'b0000;
    endtask

    task automatic press_key(input logic [3:0] b);
        KEY = ~b;
        ticks(1);
        KEY = 4'b1111;
    endtask

    initial begin
        SW  = '0;
        KEY = 4'b1111;
        ticks(3);
        chk("rst_hex",  {2'b0, HEX0}, {2'b0, H1});
        chk("rst_ledg", LEDG, 9'b0_0001_1000);
        chk("rst_ledr", {5'b0, LEDR}, 9'd0);
        SW[17] = 1'b1;
        ticks(2);
        chk("idle_noreq", LEDG, 9'b0_0001_1000);

        // Trip 1 -> 4
        pulse_sw(4'b1000);
        chk("t1_ledr", {5'b0, LEDR}, 9'b1000);
        chk("t1_idle", LEDG, 9'b1_0001_1000);
        ticks(1);
        chk("t1_up", LEDG, 9'b1_0001_0001);
        ticks(49);
        chk("t1_f1_last", {2'b0, HEX0}, {2'b0, H1});
        ticks(1);
        chk("t1_f2", {2'b0, HEX0}, {2'b0, H2});
        ticks(50);
        chk("t1_f3", {2'b0, HEX0}, {2'b0, H3});
        ticks(50);
        chk("t1_f4", {2'b0, HEX0}, {2'b0, H4});
        chk("t1_door", LEDG, 9'b0_1000_0100);
        chk("t1_ledr0", {5'b0, LEDR}, 9'd0);
        ticks(48);
        press_key(4'b1000);
        chk("t1_key_ign", {5'b0, LEDR}, 9'd0);
        ticks(50);
        chk("t1_door_last", LEDG, 9'b0_1000_0100);
        ticks(1);
        chk("t1_closed", LEDG, 9'b0_1000_1000);

        // Trip 4 -> 2
        pulse_sw(4'b0010);
        chk("t2_ledr", {5'b0, LEDR}, 9'b0010);
        ticks(1);
        chk("t2_down", LEDG, 9'b1_1000_0010);
        ticks(99);
        chk("t2_f3_moving", LEDG, 9'b1_0100_0010);
        ticks(1);
        chk("t2_f2", {2'b0, HEX0}, {2'b0, H2});
        chk("t2_door", LEDG, 9'b0_0010_0100);
        ticks(99);
        chk("t2_door_last", LEDG, 9'b0_0010_0100);
        ticks(1);
        chk("t2_closed", LEDG, 9'b0_0010_1000);

        // Calls below and above while heading down: floor 1 first, then 3
        pulse_sw(4'b0101);
        chk("t3_ledr", {5'b0, LEDR}, 9'b0101);
        ticks(1);
        chk("t3_down", LEDG, 9'b1_0010_0010);
        ticks(50);
        chk("t3_f1_door", LEDG, 9'b1_0001_0100);
        chk("t3_ledr_a", {5'b0, LEDR}, 9'b0100);
        ticks(100);
        chk("t3_idle", LEDG, 9'b1_0001_1000);
        ticks(1);
        chk("t3_rev_up", LEDG, 9'b1_0001_0001);
        ticks(100);
        chk("t3_f3", {2'b0, HEX0}, {2'b0, H3});
        chk("t3_f3_door", LEDG, 9'b0_0100_0100);
        chk("t3_ledr_b", {5'b0, LEDR}, 9'd0);
        ticks(100);
        chk("t3_closed", LEDG, 9'b0_0100_1000);

        // Cabin call at current floor
        press_key(4'b0100);
        chk("t4_ledr", {5'b0, LEDR}, 9'b0100);
        ticks(1);
        chk("t4_door", LEDG, 9'b0_0100_0100);
        chk("t4_ledr0", {5'b0, LEDR}, 9'd0);
        ticks(99);
        chk("t4_hex", {2'b0, HEX0}, {2'b0, H3});
        chk("t4_door_last", LEDG, 9'b0_0100_0100);
        ticks(1);
        chk("t4_closed", LEDG, 9'b0_0100_1000);

        // Async reset mid-move
        pulse_sw(4'b0001);
        ticks(60);
        chk("t5_f2_moving", LEDG, 9'b1_0010_0010);
        SW[17] = 1'b0;
        #1;
        chk("t5_rst_hex", {2'b0, HEX0}, {2'b0, H1});
        chk("t5_rst_ledg", LEDG, 9'b0_0001_1000);
        chk("t5_rst_ledr", {5'b0, LEDR}, 9'd0);
        ticks(1);
        SW[17] = 1'b1;
        ticks(5);
        chk("t5_stays", LEDG, 9'b0_0001_1000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
